breakout_game_ctrl: RTL
=======================

Name: breakout_game_ctrl

Overview:
- Parametrised next-generation Breakout game controller: owns game state, lives, ball and paddle kinematics in fixed point, and speed levels.
- Sits between the VGA timing/renderer (frame_pulse, per-pixel collision strobes) and the block field (reset_state, block-hit reporting).
- Adds pause, game-over, ball-follows-paddle serve, configurable paddle segment count and saturating paddle clamping.

Parameters:
FRAC_BITS, 2, fractional bits of ball position; 1 pixel = 2^FRAC_BITS units
VEL_W, 5, unsigned velocity magnitude width, in position units
LIVES, 3, lives loaded at reset and new game; LIVES_W = $clog2(LIVES+1)
NUM_SEGMENTS, 6, paddle segments, even, >= 2; SEG_W = $clog2(NUM_SEGMENTS)
BASE_VEL_Y, 4, vertical speed magnitude at level 0
INITIAL_VEL_X, 4, horizontal speed magnitude at serve
PADDLE_WIDTH, 64, paddle width in pixels
PADDLE_SPEED, 2, paddle pixels per frame
BORDER_WIDTH, 8, side wall width in pixels
BALL_SIZE, 4, ball edge length in pixels
SERVE_Y, 448, ball top row while serving
OOB_Y, 476, ball_y at or above this means out of bounds
HITS_PER_LEVEL, 8, block-hit frames per speed level
MAX_LEVEL, 3, speed_level saturation value

Ports:
clk  in  1  system clock
nRst  in  1  reset, synchronous, active-low
frame_pulse  in  1  one-cycle end-of-frame strobe
btn_action  in  1  serve / restart
btn_left  in  1  paddle left
btn_right  in  1  paddle right
btn_pause  in  1  pause toggle (level)
cmd_stop_game  in  1  abort to START with fresh game
collision  in  1  ball pixel overlaps something this cycle
block_collision  in  1  overlap is a block
paddle_collision  in  1  overlap is the paddle
paddle_segment  in  SEG_W  segment index under the ball
ball_top_col, ball_left_col, ball_bottom_col, ball_right_col  in  1 each  ball edge involved
ball_x  out  10  ball left pixel
ball_y  out  9  ball top pixel
paddle_x  out  10  paddle left pixel
game_state  out  2  0 START, 1 PLAYING, 2 PAUSED, 3 GAME_OVER
lives  out  LIVES_W  remaining lives
speed_level  out  2  current level
ball_out_of_bounds  out  1  combinational: ball_y >= OOB_Y, PLAYING only
latched_ball_block_collision  out  1  block hit seen this frame
reset_state  out  1  registered one-cycle pulse on entering GAME_OVER

Behaviour:
- Reset (nRst=0 at clk edge): START, lives=LIVES, speed_level=0, hit counter=0, paddle_x=320-PADDLE_WIDTH/2, ball in serve position, dir_x=+, dir_y=-, mag_x=INITIAL_VEL_X, all latches 0, reset_state=0. A mid-frame reset discards latched collisions.
- Latches: on frame_pulse all clear; otherwise on collision each latch ORs its input. Clear wins when collision coincides with frame_pulse. paddle_segment is captured whenever paddle_collision=1.
- All game updates occur only on frame_pulse, from values latched before that edge.
- START: ball_x=paddle_x+PADDLE_WIDTH/2-BALL_SIZE/2, ball_y=SERVE_Y. btn_action -> PLAYING with dir_y=-, dir_x=+, mag_x=INITIAL_VEL_X.
- PLAYING priority: cmd_stop_game > out-of-bounds > btn_pause rising edge > motion.
  - cmd_stop_game -> START, lives=LIVES, level=0.
  - Out of bounds: lives>1 -> lives-1, START. lives==1 -> lives=0, GAME_OVER, reset_state pulses.
  - Pause edge -> PAUSED.
- Pause edge detection uses btn_pause sampled at each frame_pulse.
- Motion:
  - Paddle hit (paddle AND bottom latched): dir_y=-. mag_x is -(N/2-seg) for seg<N/2, else seg-N/2+1. Segments >= NUM_SEGMENTS keep mag_x and dir_x.
  - Otherwise dir_y flips iff top XOR bottom. dir_x flips iff left XOR right and NOT(top XOR bottom). All four latched: no change.
  - Position += signed velocity; vertical magnitude = BASE_VEL_Y + speed_level.
- Level: each frame with a latched block hit increments the hit counter. At HITS_PER_LEVEL the counter returns to 0 and speed_level increments, saturating at MAX_LEVEL.
- PAUSED: ball and paddle frozen. Pause edge -> PLAYING. cmd_stop_game -> START.
- GAME_OVER: frozen. btn_action -> START with lives=LIVES, level=0.
- Paddle, in START and PLAYING: left XOR right moves PADDLE_SPEED, clamped to [BORDER_WIDTH, 640-BORDER_WIDTH-PADDLE_WIDTH]. Both pressed -> hold.

Optional Feature:
BREAKOUT_SPEEDUP_EN: defined -> speed_level logic as above. Undefined -> speed_level tied 0, hit counter removed, vertical speed constant BASE_VEL_Y.

Decomposition:
- breakout_pkg: game-state encoding, 640/480 screen constants, velocity sign/magnitude typedef.
- Sub-module breakout_collision_latch: latches plus segment capture.

Test Plan:
- Reset, then btn_action on frame_pulse -> game_state=1. Next frame: ball_y decreases by 1 pixel (BASE_VEL_Y=4, FRAC_BITS=2).
- Bottom+paddle collision with segment 0 latched -> mag_x=-3, dir_y up. Segment 5 -> +3. Segment 7 -> x unchanged.
- Left+top latched -> y flips only. Left only -> x flips. All four -> velocity unchanged.
- Ball reaches y=476 with lives=1 -> lives=0, state=3, reset_state high exactly one cycle. btn_action -> state=0, lives=3.
- btn_pause held across 3 frames -> PAUSED once with ball frozen. Release, press again -> PLAYING.
- Paddle at 570 with btn_right held -> stops at 568. 8 block-hit frames -> speed_level=1 (macro on), 0 (macro off).

Source files
------------

// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared types and screen constants for the breakout game controller
package breakout_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_START     = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_PAUSED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    // Velocity is kept as sign + unsigned magnitude; DIR_NEG means left / up.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } vel_dir_e;

    typedef struct packed {
        logic top;
        logic bottom;
        logic left;
        logic right;
        logic block;
        logic paddle;
    } col_flags_t;

    function automatic vel_dir_e flip_dir(input vel_dir_e d);
        return (d == DIR_POS) ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/breakout_collision_latch.sv
// rtl/breakout_collision_latch.sv - per-frame collision flag latches and paddle segment capture
module breakout_collision_latch
    import breakout_pkg::*;
#(
    parameter int SEG_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_pulse_i,
    input  logic             collision_i,
    input  col_flags_t       flags_i,
    input  logic [SEG_W-1:0] segment_i,
    output col_flags_t       flags_o,
    output logic [SEG_W-1:0] segment_o
);

    col_flags_t       flags_q;
    logic [SEG_W-1:0] segment_q;

    // Frame clear has priority so the game logic never sees next-frame hits early.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flags_q   <= '0;
            segment_q <= '0;
        end else begin
            if (frame_pulse_i) begin
                flags_q <= '0;
            end else if (collision_i) begin
                flags_q <= flags_q | flags_i;
            end
            if (flags_i.paddle) begin
                segment_q <= segment_i;
            end
        end
    end

    assign flags_o   = flags_q;
    assign segment_o = segment_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// rtl/breakout_game_ctrl.sv - breakout game FSM, ball/paddle kinematics, lives and speed level
// Optional speed levels enabled by defining BREAKOUT_SPEEDUP_EN.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int FRAC_BITS      = 2,
    parameter int VEL_W          = 5,
    parameter int LIVES          = 3,
    parameter int NUM_SEGMENTS   = 6,
    parameter int BASE_VEL_Y     = 4,
    parameter int INITIAL_VEL_X  = 4,
    parameter int PADDLE_WIDTH   = 64,
    parameter int PADDLE_SPEED   = 2,
    parameter int BORDER_WIDTH   = 8,
    parameter int BALL_SIZE      = 4,
    parameter int SERVE_Y        = 448,
    parameter int OOB_Y          = 476,
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 3,
    localparam int LIVES_W       = $clog2(LIVES + 1),
    localparam int SEG_W         = $clog2(NUM_SEGMENTS)
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               frame_pulse,
    input  logic               btn_action,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_pause,
    input  logic               cmd_stop_game,
    input  logic               collision,
    input  logic               block_collision,
    input  logic               paddle_collision,
    input  logic [SEG_W-1:0]   paddle_segment,
    input  logic               ball_top_col,
    input  logic               ball_left_col,
    input  logic               ball_bottom_col,
    input  logic               ball_right_col,
    output logic [9:0]         ball_x,
    output logic [8:0]         ball_y,
    output logic [9:0]         paddle_x,
    output logic [1:0]         game_state,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         speed_level,
    output logic               ball_out_of_bounds,
    output logic               latched_ball_block_collision,
    output logic               reset_state
);

    localparam int PX_W = 10 + FRAC_BITS;
    localparam int PY_W = 9 + FRAC_BITS;
    localparam int HALF = NUM_SEGMENTS / 2;

    localparam logic [9:0]         PADDLE_MIN   = 10'(BORDER_WIDTH);
    localparam logic [9:0]         PADDLE_MAX   = 10'(SCREEN_W - BORDER_WIDTH - PADDLE_WIDTH);
    localparam logic [9:0]         PADDLE_STEP  = 10'(PADDLE_SPEED);
    localparam logic [9:0]         PADDLE_RESET = 10'(SCREEN_W / 2 - PADDLE_WIDTH / 2);
    localparam logic [9:0]         SERVE_OFF    = 10'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);
    localparam logic [8:0]         SERVE_ROW    = 9'(SERVE_Y);
    localparam logic [8:0]         OOB_ROW      = 9'(OOB_Y);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
    localparam logic [VEL_W-1:0]   VEL_X_INIT   = VEL_W'(INITIAL_VEL_X);

    game_state_e        state_q;
    logic [LIVES_W-1:0] lives_q;
    logic [1:0]         level_q;
    logic [9:0]         paddle_x_q, paddle_x_d;
    logic [PX_W-1:0]    pos_x_q, pos_x_d;
    logic [PY_W-1:0]    pos_y_q, pos_y_d;
    vel_dir_e           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [VEL_W-1:0]   mag_x_q, mag_x_d, vel_y_mag;
    logic               pause_prev_q, reset_state_q, pause_edge;

    col_flags_t         col_in, lat;
    logic [SEG_W-1:0]   lat_seg;
    int                 seg_idx;

    assign col_in = '{top: ball_top_col, bottom: ball_bottom_col, left: ball_left_col,
                      right: ball_right_col, block: block_collision, paddle: paddle_collision};

    breakout_collision_latch #(.SEG_W(SEG_W)) u_latch (
        .clk_i         (clk),
        .rst_ni        (nRst),
        .frame_pulse_i (frame_pulse),
        .collision_i   (collision),
        .flags_i       (col_in),
        .segment_i     (paddle_segment),
        .flags_o       (lat),
        .segment_o     (lat_seg)
    );

    assign seg_idx    = int'(lat_seg);
    assign pause_edge = btn_pause & ~pause_prev_q;

    always_comb begin
        paddle_x_d = paddle_x_q;
        if (btn_left && !btn_right) begin
            paddle_x_d = (paddle_x_q < PADDLE_MIN + PADDLE_STEP) ? PADDLE_MIN : paddle_x_q - PADDLE_STEP;
        end else if (btn_right && !btn_left) begin
            paddle_x_d = (paddle_x_q > PADDLE_MAX - PADDLE_STEP) ? PADDLE_MAX : paddle_x_q + PADDLE_STEP;
        end
    end

    // Reflection is resolved first, then the ball moves with the new velocity.
    always_comb begin
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        mag_x_d = mag_x_q;
        if (lat.paddle && lat.bottom) begin
            dir_y_d = DIR_NEG;
            if (seg_idx < NUM_SEGMENTS) begin
                if (seg_idx < HALF) begin
                    dir_x_d = DIR_NEG;
                    mag_x_d = VEL_W'(HALF - seg_idx);
                end else begin
                    dir_x_d = DIR_POS;
                    mag_x_d = VEL_W'(seg_idx - HALF + 1);
                end
            end
        end else if (lat.top ^ lat.bottom) begin
            dir_y_d = flip_dir(dir_y_q);
        end else if (lat.left ^ lat.right) begin
            dir_x_d = flip_dir(dir_x_q);
        end
        pos_x_d = (dir_x_d == DIR_NEG) ? pos_x_q - PX_W'(mag_x_d) : pos_x_q + PX_W'(mag_x_d);
        pos_y_d = (dir_y_d == DIR_NEG) ? pos_y_q - PY_W'(vel_y_mag) : pos_y_q + PY_W'(vel_y_mag);
    end

`ifdef BREAKOUT_SPEEDUP_EN
    localparam int               HITS_W    = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [HITS_W-1:0] HITS_LAST = HITS_W'(HITS_PER_LEVEL - 1);
    localparam logic [1:0]        LEVEL_MAX = 2'(MAX_LEVEL);

    logic [HITS_W-1:0] hits_q;
    logic              level_clr, level_hit;

    assign level_clr = frame_pulse &&
                       ((((state_q == ST_PLAYING) || (state_q == ST_PAUSED)) && cmd_stop_game) ||
                        ((state_q == ST_GAME_OVER) && btn_action));
    assign level_hit = frame_pulse && (state_q == ST_PLAYING) && !cmd_stop_game &&
                       !ball_out_of_bounds && !pause_edge && lat.block;

    always_ff @(posedge clk) begin
        if (!nRst || level_clr) begin
            hits_q  <= '0;
            level_q <= 2'd0;
        end else if (level_hit) begin
            if (hits_q == HITS_LAST) begin
                hits_q <= '0;
                if (level_q != LEVEL_MAX) begin
                    level_q <= level_q + 2'd1;
                end
            end else begin
                hits_q <= hits_q + HITS_W'(1);
            end
        end
    end

    assign vel_y_mag = VEL_W'(BASE_VEL_Y) + VEL_W'(level_q);
`else
    assign level_q   = 2'd0;
    assign vel_y_mag = VEL_W'(BASE_VEL_Y);
`endif

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q       <= ST_START;
            lives_q       <= LIVES_INIT;
            paddle_x_q    <= PADDLE_RESET;
            pos_x_q       <= {PADDLE_RESET + SERVE_OFF, {FRAC_BITS{1'b0}}};
            pos_y_q       <= {SERVE_ROW, {FRAC_BITS{1'b0}}};
            dir_x_q       <= DIR_POS;
            dir_y_q       <= DIR_NEG;
            mag_x_q       <= VEL_X_INIT;
            pause_prev_q  <= 1'b0;
            reset_state_q <= 1'b0;
        end else begin
            reset_state_q <= 1'b0;
            if (frame_pulse) begin
                pause_prev_q <= btn_pause;
                if ((state_q == ST_START) || (state_q == ST_PLAYING)) begin
                    paddle_x_q <= paddle_x_d;
                end
                case (state_q)
                    ST_START: begin
                        if (btn_action) begin
                            state_q <= ST_PLAYING;
                            dir_x_q <= DIR_POS;
                            dir_y_q <= DIR_NEG;
                            mag_x_q <= VEL_X_INIT;
                            pos_x_q <= {paddle_x_d + SERVE_OFF, {FRAC_BITS{1'b0}}};
                            pos_y_q <= {SERVE_ROW, {FRAC_BITS{1'b0}}};
                        end
                    end
                    ST_PLAYING: begin
                        if (cmd_stop_game) begin
                            state_q <= ST_START;
                            lives_q <= LIVES_INIT;
                        end else if (ball_out_of_bounds) begin
                            if (lives_q > LIVES_W'(1)) begin
                                lives_q <= lives_q - LIVES_W'(1);
                                state_q <= ST_START;
                            end else begin
                                lives_q       <= '0;
                                state_q       <= ST_GAME_OVER;
                                reset_state_q <= 1'b1;
                            end
                        end else if (pause_edge) begin
                            state_q <= ST_PAUSED;
                        end else begin
                            dir_x_q <= dir_x_d;
                            dir_y_q <= dir_y_d;
                            mag_x_q <= mag_x_d;
                            pos_x_q <= pos_x_d;
                            pos_y_q <= pos_y_d;
                        end
                    end
                    ST_PAUSED: begin
                        if (cmd_stop_game) begin
                            state_q <= ST_START;
                            lives_q <= LIVES_INIT;
                        end else if (pause_edge) begin
                            state_q <= ST_PLAYING;
                        end
                    end
                    default: begin
                        if (btn_action) begin
                            state_q <= ST_START;
                            lives_q <= LIVES_INIT;
                        end
                    end
                endcase
            end
        end
    end

    // While serving the ball rides on the paddle rather than its own position.
    assign ball_x = (state_q == ST_START) ? paddle_x_q + SERVE_OFF : pos_x_q[PX_W-1:FRAC_BITS];
    assign ball_y = (state_q == ST_START) ? SERVE_ROW : pos_y_q[PY_W-1:FRAC_BITS];

    assign paddle_x                     = paddle_x_q;
    assign game_state                   = state_q;
    assign lives                        = lives_q;
    assign speed_level                  = level_q;
    assign ball_out_of_bounds           = (state_q == ST_PLAYING) && (ball_y >= OOB_ROW);
    assign latched_ball_block_collision = lat.block;
    assign reset_state                  = reset_state_q;

endmodule
